conv1_sched: RTL and testbench
==============================

Name: conv1_sched

Overview:
- Frame-level sequencer for the first convolution layer.
- Walks every valid K x K window of an IMG_H x IMG_W input map. For each window it drives the weight-ROM start line, the MAC enable/clear and the pixel tap coordinates.
- Presents each finished output position to the downstream buffer via a valid/ready handshake.
- Sits between the frame/line-buffer control, the conv1 kernel weight ROM and the conv1 MAC array.

Parameters:
- IMG_W, 28, input map width in pixels
- IMG_H, 28, input map height in pixels
- K, 5, kernel side; TAPS = K*K
- WLAT, 2, cycles from kernel_start rising to first valid weight on the ROM output
- MAC_LAT, 2, MAC pipeline depth after last tap (minimum 1)
- Derived: OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1; RW = $clog2(IMG_H), CW = $clog2(IMG_W), TW = $clog2(TAPS)

Ports:
- clk  in  1  clock, rising edge
- n_reset  in  1  synchronous active-low reset
- frame_start  in  1  single-cycle frame request; sampled only in IDLE
- in_ready  in  1  line buffer holds all rows needed by the current window
- kernel_start  out  1  start line to the conv1 weight ROM
- mac_en  out  1  MAC accumulate enable for the current tap
- mac_clear  out  1  first tap of a window: MAC loads product instead of accumulating
- tap_idx  out  TW  tap index 0..TAPS-1 being accumulated
- pix_row  out  RW  input row of the current tap (win_row + tap_idx/K)
- pix_col  out  CW  input column of the current tap (win_col + tap_idx%K)
- out_valid  out  1  MAC result for (out_row, out_col) is final
- out_ready  in  1  downstream accepts the result
- out_row  out  RW  output row of the presented result
- out_col  out  CW  output column of the presented result
- busy  out  1  state != IDLE
- done  out  1  single-cycle pulse after the last window is accepted

Behaviour:
- Reset: sampled on the clk edge while n_reset=0.
  - State goes to IDLE; window row/col, cycle counter and tap counter go to 0.
  - All outputs are 0 on reset and in IDLE.
  - Reset mid-frame aborts the frame with no done pulse.
- States: IDLE, WAIT, RUN, DRAIN, WRITE, DONE.
- IDLE:
  - frame_start=1 -> WAIT with window (0,0).
  - frame_start in any other state is ignored.
- WAIT:
  - kernel_start=0.
  - in_ready=1 -> RUN next cycle; otherwise stay in WAIT indefinitely.
- RUN: lasts exactly WLAT+TAPS cycles, with cycle counter c = 0..WLAT+TAPS-1.
  - kernel_start=1 for every RUN cycle.
  - mac_en=1 iff c>=WLAT; tap_idx = c-WLAT.
  - mac_clear=1 only at c=WLAT.
  - pix_row/pix_col are valid when mac_en=1 and 0 otherwise.
  - in_ready is not re-checked during RUN.
  - After the last RUN cycle -> DRAIN.
- DRAIN:
  - Lasts MAC_LAT cycles.
  - kernel_start=0, which realigns the ROM counter for the next window.
  - Then -> WRITE.
- WRITE:
  - out_valid=1, out_row/out_col = current window position, held stable until out_ready=1.
  - Handshake completes in a cycle with out_valid=1 and out_ready=1.
  - If win_col<OUT_W-1: col+1, then -> WAIT.
  - Otherwise col wraps to 0 and row+1, then -> WAIT.
  - If the window was (OUT_H-1, OUT_W-1) -> DONE.
- DONE:
  - done=1 for one cycle, then -> IDLE. busy=1 in DONE.
- Counters:
  - tap_idx/K and tap_idx%K are computed with row/col tap sub-counters, not division.
  - The column sub-counter wraps at K-1.
- Timing: with in_ready=out_ready=1, each window takes 1+WLAT+TAPS+MAC_LAT+1 cycles (31 at defaults).
- Back-pressure: out_ready=0 stalls only WRITE; no tap is ever skipped or repeated.

Test Plan:
- Reset and idle: hold n_reset=0 for 3 cycles, then release with no frame_start -> all outputs 0 and busy=0 for 50 cycles.
- Small frame, IMG_W=IMG_H=6, K=5, defaults otherwise, in_ready=out_ready=1, frame_start pulsed at edge E0:
  - out_valid for (0,0),(0,1),(1,0),(1,1) at cycles 30, 61, 92, 123 after E0.
  - done pulses at cycle 124; busy falls at 125.
- Tap sequencing for window (1,1):
  - 25 mac_en cycles with tap_idx 0..24 contiguous.
  - mac_clear only with tap_idx=0.
  - pix_row/pix_col run from (1,1) to (5,5) row-major.
  - kernel_start high for exactly 27 cycles, low for at least 3 cycles before the next RUN.
- Back-pressure: out_ready=0 for 10 cycles during WRITE of (0,1) -> out_valid and out_row/out_col held stable; the next window starts 1 cycle after acceptance.
- in_ready=0 for 7 cycles in WAIT -> kernel_start and mac_en stay 0; RUN begins on the cycle after in_ready rises.
- Reset mid-RUN at tap 12:
  - Next cycle shows IDLE with all outputs 0 and no done.
  - A new frame_start restarts at window (0,0).
  - frame_start pulsed while busy has no effect.

Source files
------------

// File: rtl/conv1_sched_if.sv
// Handshake and tap bus between the conv1 scheduler and its neighbours
// (line-buffer control, weight ROM, MAC array, output buffer).
interface conv1_sched_if #(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28,
   parameter int K     = 5
);
   localparam int TAPS = K * K;
   localparam int RW   = $clog2(IMG_H);
   localparam int CW   = $clog2(IMG_W);
   localparam int TW   = $clog2(TAPS);

   logic          frame_start;
   logic          in_ready;
   logic          kernel_start;
   logic          mac_en;
   logic          mac_clear;
   logic [TW-1:0] tap_idx;
   logic [RW-1:0] pix_row;
   logic [CW-1:0] pix_col;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] out_row;
   logic [CW-1:0] out_col;
   logic          busy;
   logic          done;

   // scheduler side
   modport master (
      input  frame_start, in_ready, out_ready,
      output kernel_start, mac_en, mac_clear, tap_idx, pix_row, pix_col,
             out_valid, out_row, out_col, busy, done
   );

   // environment side
   modport slave (
      output frame_start, in_ready, out_ready,
      input  kernel_start, mac_en, mac_clear, tap_idx, pix_row, pix_col,
             out_valid, out_row, out_col, busy, done
   );
endinterface

// File: rtl/conv1_sched.sv
// Frame-level sequencer for the first convolution layer: walks every valid
// K x K window, sequences weight-ROM start, MAC taps and result handoff.
module conv1_sched #(
   parameter int IMG_W   = 28,
   parameter int IMG_H   = 28,
   parameter int K       = 5,
   parameter int WLAT    = 2,
   parameter int MAC_LAT = 2
) (
   input logic           clk,
   input logic           n_reset,
   conv1_sched_if.master bus
);
   localparam int TAPS    = K * K;
   localparam int OUT_W   = IMG_W - K + 1;
   localparam int OUT_H   = IMG_H - K + 1;
   localparam int RW      = $clog2(IMG_H);
   localparam int CW      = $clog2(IMG_W);
   localparam int TW      = $clog2(TAPS);
   localparam int KW      = $clog2(K + 1);
   localparam int RUN_LEN = WLAT + TAPS;
   localparam int CMAX    = (RUN_LEN > MAC_LAT) ? RUN_LEN : MAC_LAT;
   localparam int NW      = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_RUN, S_DRAIN, S_WRITE, S_DONE
   } state_t;

   state_t        state, nxt;
   logic [RW-1:0] win_row;
   logic [CW-1:0] win_col;
   logic [NW-1:0] cnt;
   logic [TW-1:0] tap;
   logic [KW-1:0] trow, tcol;

   logic tap_phase, run_last, drain_last, last_col, last_row;

   assign tap_phase  = (state == S_RUN) && (cnt >= NW'(WLAT));
   assign run_last   = (cnt == NW'(RUN_LEN - 1));
   assign drain_last = (cnt == NW'(MAC_LAT - 1));
   assign last_col   = (win_col == CW'(OUT_W - 1));
   assign last_row   = (win_row == RW'(OUT_H - 1));

   // state register
   always_ff @(posedge clk) begin
      if (!n_reset) state <= S_IDLE;
      else          state <= nxt;
   end

   // next-state decode
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  if (bus.frame_start) nxt = S_WAIT;
         S_WAIT:  if (bus.in_ready)    nxt = S_RUN;
         S_RUN:   if (run_last)        nxt = S_DRAIN;
         S_DRAIN: if (drain_last)      nxt = S_WRITE;
         S_WRITE: if (bus.out_ready)   nxt = (last_row && last_col) ? S_DONE : S_WAIT;
         S_DONE:  nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // window position, phase cycle counter and tap row/col sub-counters
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         win_row <= '0;
         win_col <= '0;
         cnt     <= '0;
         tap     <= '0;
         trow    <= '0;
         tcol    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               win_row <= '0;
               win_col <= '0;
               cnt     <= '0;
            end
            S_WAIT: begin
               cnt  <= '0;
               tap  <= '0;
               trow <= '0;
               tcol <= '0;
            end
            S_RUN: begin
               cnt <= run_last ? '0 : cnt + 1'b1;
               if (tap_phase) begin
                  tap <= tap + 1'b1;
                  if (tcol == KW'(K - 1)) begin
                     tcol <= '0;
                     trow <= trow + 1'b1;
                  end else begin
                     tcol <= tcol + 1'b1;
                  end
               end
            end
            S_DRAIN: cnt <= drain_last ? '0 : cnt + 1'b1;
            S_WRITE: begin
               if (bus.out_ready) begin
                  if (last_col) begin
                     win_col <= '0;
                     win_row <= last_row ? '0 : win_row + 1'b1;
                  end else begin
                     win_col <= win_col + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Moore outputs; tap bus is zero outside the accumulate phase
   always_comb begin
      bus.kernel_start = 1'b0;
      bus.mac_en       = 1'b0;
      bus.mac_clear    = 1'b0;
      bus.tap_idx      = '0;
      bus.pix_row      = '0;
      bus.pix_col      = '0;
      bus.out_valid    = 1'b0;
      bus.out_row      = '0;
      bus.out_col      = '0;
      bus.done         = 1'b0;
      bus.busy         = (state != S_IDLE);
      case (state)
         S_RUN: begin
            bus.kernel_start = 1'b1;
            if (tap_phase) begin
               bus.mac_en    = 1'b1;
               bus.mac_clear = (cnt == NW'(WLAT));
               bus.tap_idx   = tap;
               bus.pix_row   = win_row + RW'(trow);
               bus.pix_col   = win_col + CW'(tcol);
            end
         end
         S_WRITE: begin
            bus.out_valid = 1'b1;
            bus.out_row   = win_row;
            bus.out_col   = win_col;
         end
         S_DONE: bus.done = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_conv1_sched.sv
// Self-checking bench for conv1_sched on a 6x6 map with a 5x5 kernel:
// per-window script of expected activity derived from window/tap arithmetic,
// with randomized stalls and random noise on inputs that must be ignored.
module tb_conv1_sched;
   localparam int IMG_W   = 6;
   localparam int IMG_H   = 6;
   localparam int K       = 5;
   localparam int WLAT    = 2;
   localparam int MAC_LAT = 2;
   localparam int TAPS    = K * K;
   localparam int OUT_W   = IMG_W - K + 1;
   localparam int OUT_H   = IMG_H - K + 1;
   localparam int NWIN    = OUT_W * OUT_H;
   localparam int RUN_LEN = WLAT + TAPS;
   localparam int WIN_CYC = 1 + RUN_LEN + MAC_LAT + 1;

   logic clk = 1'b0;
   logic n_reset = 1'b0;

   conv1_sched_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)) bus ();

   conv1_sched #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .WLAT(WLAT), .MAC_LAT(MAC_LAT)
   ) dut (
      .clk(clk),
      .n_reset(n_reset),
      .bus(bus.master)
   );

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   int          cyc_no = 0;
   int          stall_in [NWIN];
   int          stall_out[NWIN];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_no);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc_no++;
   endtask

   task automatic expect_outs(input string ph, input logic ks, input logic en, input logic clr,
                              input int tap, input int pr, input int pc, input logic ov,
                              input int orow, input int ocol, input logic bsy, input logic dn);
      check_eq({ph, ".kernel_start"}, 32'(bus.kernel_start), 32'(ks));
      check_eq({ph, ".mac_en"},       32'(bus.mac_en),       32'(en));
      check_eq({ph, ".mac_clear"},    32'(bus.mac_clear),    32'(clr));
      check_eq({ph, ".tap_idx"},      32'(bus.tap_idx),      32'(tap));
      check_eq({ph, ".pix_row"},      32'(bus.pix_row),      32'(pr));
      check_eq({ph, ".pix_col"},      32'(bus.pix_col),      32'(pc));
      check_eq({ph, ".out_valid"},    32'(bus.out_valid),    32'(ov));
      check_eq({ph, ".out_row"},      32'(bus.out_row),      32'(orow));
      check_eq({ph, ".out_col"},      32'(bus.out_col),      32'(ocol));
      check_eq({ph, ".busy"},         32'(bus.busy),         32'(bsy));
      check_eq({ph, ".done"},         32'(bus.done),         32'(dn));
   endtask

   task automatic expect_idle(input string ph);
      expect_outs(ph, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // inputs that must not matter in the current state get random values
   task automatic noise();
      bus.frame_start = ($urandom_range(0, 3) == 0);
      bus.in_ready    = 1'($urandom);
      bus.out_ready   = 1'($urandom);
   endtask

   // One frame; abort_win/abort_c >= 0 asserts reset at that RUN cycle.
   task automatic run_frame(input int abort_win, input int abort_c);
      int  t_exp, w, t;
      logic en;
      expect_idle("pre");
      bus.frame_start = 1'b1;
      step();
      bus.frame_start = 1'b0;
      cyc_no = 0;
      t_exp  = 0;
      for (int r = 0; r < OUT_H; r++) begin
         for (int c = 0; c < OUT_W; c++) begin
            w = r * OUT_W + c;
            for (int i = 0; i <= stall_in[w]; i++) begin
               expect_outs("wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
               noise();
               bus.in_ready = (i == stall_in[w]);
               step();
            end
            for (int k = 0; k < RUN_LEN; k++) begin
               en = (k >= WLAT);
               t  = en ? k - WLAT : 0;
               expect_outs("run", 1, en, en && (t == 0), t,
                           en ? r + t / K : 0, en ? c + t % K : 0, 0, 0, 0, 1, 0);
               if (w == abort_win && k == abort_c) begin
                  n_reset = 1'b0;
                  step();
                  expect_idle("abort");
                  n_reset = 1'b1;
                  bus.frame_start = 1'b0;
                  for (int j = 0; j < 5; j++) begin
                     step();
                     expect_idle("post_abort");
                  end
                  return;
               end
               noise();
               step();
            end
            for (int k = 0; k < MAC_LAT; k++) begin
               expect_outs("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
               noise();
               step();
            end
            check_eq("write_cycle", 32'(cyc_no), 32'(t_exp + stall_in[w] + WIN_CYC - 1));
            for (int j = 0; j <= stall_out[w]; j++) begin
               expect_outs("write", 0, 0, 0, 0, 0, 0, 1, r, c, 1, 0);
               noise();
               bus.out_ready = (j == stall_out[w]);
               step();
            end
            t_exp += WIN_CYC + stall_in[w] + stall_out[w];
         end
      end
      check_eq("done_cycle", 32'(cyc_no), 32'(t_exp));
      expect_outs("done", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      noise();
      step();
      bus.frame_start = 1'b0;
      check_eq("idle_cycle", 32'(cyc_no), 32'(t_exp + 1));
      expect_idle("after_done");
   endtask

   task automatic clear_stalls();
      for (int i = 0; i < NWIN; i++) begin
         stall_in[i]  = 0;
         stall_out[i] = 0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.frame_start = 1'b0;
      bus.in_ready    = 1'b0;
      bus.out_ready   = 1'b0;
      n_reset         = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         step();
         expect_idle("reset");
      end
      n_reset = 1'b1;
      for (int i = 0; i < 50; i++) begin
         bus.in_ready  = 1'($urandom);
         bus.out_ready = 1'($urandom);
         step();
         expect_idle("idle");
      end

      // unstalled frame: results at 30/61/92/123, done at 124
      clear_stalls();
      run_frame(-1, -1);

      // back-pressure on (0,1), line-buffer stall on (1,0)
      clear_stalls();
      stall_out[1] = 10;
      stall_in[2]  = 7;
      run_frame(-1, -1);

      // reset in the middle of window (0,1) at tap 12, then a full restart
      clear_stalls();
      run_frame(1, WLAT + 12);
      run_frame(-1, -1);

      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < NWIN; i++) begin
            stall_in[i]  = $urandom_range(0, 4);
            stall_out[i] = $urandom_range(0, 4);
         end
         run_frame(-1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
